// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: streams one IMG_W x IMG_H raster frame into result memory.
// Optional pixel checksum enabled by defining FBW_CHECKSUM_EN.
module frame_buffer_writer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              last_pix;
    logic              arm;

    assign s_ready  = (state_q == RUN) && !mem_busy;
    assign accept   = s_valid && s_ready;
    assign last_pix = (x_q == X_MAX) && (y_q == Y_MAX);
    assign arm      = start && (state_q != RUN);

    // Next-state, raster counters and registered write port.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = s_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    if (s_last != last_pix) begin
                        err_d = 1'b1;
                    end
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_pix) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

`ifdef FBW_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Running modulo-2^16 sum of accepted pixels, cleared when armed.
    always_comb begin
        sum_d = sum_q;
        if (arm) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + 16'(s_data);
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_arm;
    assign unused_arm = arm;
    assign checksum   = '0;
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed frames with a write scoreboard and
// a cycle-level reference model for handshake and status outputs.
module tb_frame_buffer_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       mem_busy = 1'b0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [15:0] checksum;

    int tests = 0;
    int fails = 0;
    bit busy_mode = 1'b0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t sb[$];

    // reference model: 0 idle, 1 run, 2 done
    int          m_st = 0;
    int          m_cnt = 0;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_sum = '0;

    frame_buffer_writer #(
        .IMG_W(W),
        .IMG_H(H),
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .mem_busy(mem_busy),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of the writer, updated on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            m_st  <= 0;
            m_cnt <= 0;
            m_we  <= 1'b0;
            m_err <= 1'b0;
            m_sum <= '0;
            sb.delete();
        end else begin
            acc = s_valid && (m_st == 1) && !mem_busy;
            m_we <= acc;
            if (m_st != 1) begin
                if (start) begin
                    m_st  <= 1;
                    m_cnt <= 0;
                    m_err <= 1'b0;
                    m_sum <= '0;
                end
            end else if (acc) begin
                sb.push_back('{a: 4'(m_cnt), d: s_data});
                m_sum <= m_sum + {8'd0, s_data};
                if (s_last != (m_cnt == NP - 1)) m_err <= 1'b1;
                m_cnt <= m_cnt + 1;
                if (m_cnt == NP - 1) m_st <= 2;
            end
        end
    end

    // Per-cycle output monitor and scoreboard pop.
    always @(negedge clk) begin
        wr_t e;
        logic [15:0] exp_sum;
`ifdef FBW_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = '0;
`endif
        check("s_ready", 32'(s_ready), 32'((m_st == 1) && !mem_busy));
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("busy", 32'(busy), 32'(m_st == 1));
        check("done", 32'(done), 32'(m_st == 2));
        check("err", 32'(err), 32'(m_err));
        check("checksum", 32'(checksum), 32'(exp_sum));
        if (mem_we) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(e.a));
                check("mem_wdata", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
        if (busy_mode) mem_busy = ~mem_busy;
        else mem_busy = 1'b0;
        #1;
    endtask

    task automatic pulse_start(input logic with_valid, input logic [7:0] d);
        start = 1'b1;
        s_valid = with_valid;
        s_data = d;
        tick();
        start = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        logic ok;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        n = 0;
        ok = s_ready;
        while (!ok && n < 100) begin
            tick();
            ok = s_ready;
            n++;
        end
        check("handshake_timeout", 32'(ok), 32'd1);
        if (!ok) begin
            $fatal(1, "FAIL handshake_timeout: s_ready never rose");
        end
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic pixels(input int from, input int to, input int base,
                          input int step, input int last_at,
                          input int max_gap);
        for (int i = from; i < to; i++) begin
            send(8'(base + i * step), (i + 1) == last_at);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_checksum", 32'(checksum), 0);
        rst_n = 1'b1;
        tick();

        // frame A: 1..12 back to back
        pulse_start(1'b0, 8'd0);
        pixels(0, NP, 1, 1, NP, 0);
        check("A_done", 32'(done), 1);
        check("A_we_last", 32'(mem_we), 1);
        check("A_addr_last", 32'(mem_addr), 11);
        check("A_err", 32'(err), 0);
`ifdef FBW_CHECKSUM_EN
        check("A_checksum", 32'(checksum), 78);
`endif
        tick();
        tick();

        // frame B: mem_busy toggling every cycle
        busy_mode = 1'b1;
        pulse_start(1'b0, 8'd0);
        pixels(0, NP, 200, 5, NP, 0);
        busy_mode = 1'b0;
        check("B_done", 32'(done), 1);
        tick();

        // frame C: random valid gaps
        pulse_start(1'b0, 8'd0);
        pixels(0, NP, 17, 29, NP, 3);
        check("C_done", 32'(done), 1);
        tick();

        // frame D: s_last on pixel 5 only
        pulse_start(1'b0, 8'd0);
        pixels(0, 4, 9, 3, 5, 0);
        check("D_err_before", 32'(err), 0);
        pixels(4, 5, 9, 3, 5, 0);
        tick();
        check("D_err_after5", 32'(err), 1);
        pixels(5, NP, 9, 3, 5, 0);
        check("D_done", 32'(done), 1);
        check("D_err_end", 32'(err), 1);
        tick();

        // reset mid-frame after 6 pixels
        pulse_start(1'b0, 8'd0);
        pixels(0, 6, 40, 1, NP, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_we", 32'(mem_we), 0);
        check("mid_rst_mem_addr", 32'(mem_addr), 0);
        check("mid_rst_mem_wdata", 32'(mem_wdata), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_s_ready", 32'(s_ready), 0);
        check("mid_rst_checksum", 32'(checksum), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 0);
        pulse_start(1'b0, 8'd0);
        pixels(0, NP, 60, 2, NP, 0);
        check("R_done", 32'(done), 1);
        tick();

        // start during RUN is ignored
        pulse_start(1'b0, 8'd0);
        pixels(0, 3, 100, 1, NP, 0);
        pulse_start(1'b0, 8'd0);
        check("run_start_busy", 32'(busy), 1);
        pixels(3, NP, 100, 1, NP, 0);
        check("S_done", 32'(done), 1);
        tick();

        // start in DONE with s_valid high: no accept that cycle
        pulse_start(1'b1, 8'd77);
        check("restart_done_clr", 32'(done), 0);
        check("restart_err_clr", 32'(err), 0);
        check("restart_sum_clr", 32'(checksum), 0);
        pixels(0, NP, 77, 11, NP, 0);
        check("T_done", 32'(done), 1);
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
